// File: rtl/rvvi_retire_arb.sv
// rvvi_retire_arb: round-robin merge of per-hart retirement records onto a
// single RVVI trace port. Each granted record is stamped with its hart's
// running 64-bit instruction order count and registered with the hart id.
// Halted harts are masked out of arbitration. A flush request drains the
// output stage and then zeroes every order counter.
module rvvi_retire_arb #(
  parameter  int ILEN  = 32,
  parameter  int XLEN  = 32,
  parameter  int NHART = 2,
  localparam int HW    = (NHART > 1) ? $clog2(NHART) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NHART-1:0]      in_valid,
  output logic [NHART-1:0]      in_ready,
  input  logic [NHART*ILEN-1:0] in_insn,
  input  logic [NHART*XLEN-1:0] in_pc_rdata,
  input  logic [NHART*XLEN-1:0] in_pc_wdata,
  input  logic [NHART-1:0]      in_trap,
  input  logic [NHART-1:0]      in_halt,
  input  logic [NHART*2-1:0]    in_mode,
  input  logic [NHART-1:0]      clr_halt,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [HW-1:0]         out_hart,
  output logic [63:0]           out_order,
  output logic [ILEN-1:0]       out_insn,
  output logic [XLEN-1:0]       out_pc_rdata,
  output logic [XLEN-1:0]       out_pc_wdata,
  output logic                  out_trap,
  output logic                  out_halt,
  output logic [1:0]            out_mode,
  output logic [NHART-1:0]      halted,
  output logic                  busy
);

  typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, CLEAR = 2'd2} state_t;

  state_t          state_reg;
  logic            busy_reg;
  logic [HW-1:0]   last_reg;
  logic            out_valid_reg;
  logic [HW-1:0]   out_hart_reg;
  logic [63:0]     out_order_reg;
  logic [ILEN-1:0] out_insn_reg;
  logic [XLEN-1:0] out_pc_rdata_reg;
  logic [XLEN-1:0] out_pc_wdata_reg;
  logic            out_trap_reg;
  logic            out_halt_reg;
  logic [1:0]      out_mode_reg;

  logic [NHART-1:0] halted_vec;
  logic [NHART-1:0] elig;
  logic [HW:0]      cand;
  logic             grant_found;
  logic [HW-1:0]    grant_idx;
  logic             load;

  logic [ILEN-1:0] insn_arr     [NHART];
  logic [XLEN-1:0] pc_rdata_arr [NHART];
  logic [XLEN-1:0] pc_wdata_arr [NHART];
  logic [1:0]      mode_arr     [NHART];
  logic [63:0]     cnt_arr      [NHART];

  assign elig = in_valid & ~halted_vec;

  // Rotating-priority search: start just after the previous winner and wrap.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 1; k <= NHART; k++) begin
      cand = {1'b0, last_reg} + (HW+1)'(k);
      if (cand >= (HW+1)'(NHART)) cand = cand - (HW+1)'(NHART);
      if (!grant_found && (|(elig & (NHART'(1) << cand)))) begin
        grant_found = 1'b1;
        grant_idx   = cand[HW-1:0];
      end
    end
  end

  // Reset is folded in so no hart sees an accept while the block is held in reset.
  assign load     = rst_n && (state_reg == RUN) && grant_found && (!out_valid_reg || out_ready);
  assign in_ready = load ? (NHART'(1) << grant_idx) : '0;

  genvar gi;
  generate
    for (gi = 0; gi < NHART; gi++) begin : g_hart
      logic [63:0] cnt_reg;
      logic        halted_bit_reg;
      logic        hit;

      assign hit              = load && (grant_idx == HW'(gi));
      assign insn_arr[gi]     = in_insn[gi*ILEN +: ILEN];
      assign pc_rdata_arr[gi] = in_pc_rdata[gi*XLEN +: XLEN];
      assign pc_wdata_arr[gi] = in_pc_wdata[gi*XLEN +: XLEN];
      assign mode_arr[gi]     = in_mode[gi*2 +: 2];
      assign cnt_arr[gi]      = cnt_reg;
      assign halted_vec[gi]   = halted_bit_reg;

      // Order counter: every grant (trap and halt included) consumes one value; wraps naturally.
      always_ff @(posedge clk) begin
        if (!rst_n)                  cnt_reg <= '0;
        else if (state_reg == CLEAR) cnt_reg <= '0;
        else if (hit)                cnt_reg <= cnt_reg + 64'd1;
      end

      // Sticky halt flag; a halting grant outranks a same-cycle clear.
      always_ff @(posedge clk) begin
        if (!rst_n)                 halted_bit_reg <= 1'b0;
        else if (hit && in_halt[gi]) halted_bit_reg <= 1'b1;
        else if (clr_halt[gi])      halted_bit_reg <= 1'b0;
      end
    end
  endgenerate

  // Output register, round-robin pointer and RUN/DRAIN/CLEAR sequencing.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg        <= RUN;
      busy_reg         <= 1'b0;
      last_reg         <= HW'(NHART - 1);
      out_valid_reg    <= 1'b0;
      out_hart_reg     <= '0;
      out_order_reg    <= '0;
      out_insn_reg     <= '0;
      out_pc_rdata_reg <= '0;
      out_pc_wdata_reg <= '0;
      out_trap_reg     <= 1'b0;
      out_halt_reg     <= 1'b0;
      out_mode_reg     <= '0;
    end else begin
      if (load) begin
        out_valid_reg    <= 1'b1;
        out_hart_reg     <= grant_idx;
        out_order_reg    <= cnt_arr[grant_idx];
        out_insn_reg     <= insn_arr[grant_idx];
        out_pc_rdata_reg <= pc_rdata_arr[grant_idx];
        out_pc_wdata_reg <= pc_wdata_arr[grant_idx];
        out_trap_reg     <= in_trap[grant_idx];
        out_halt_reg     <= in_halt[grant_idx];
        out_mode_reg     <= mode_arr[grant_idx];
        last_reg         <= grant_idx;
      end else if (out_valid_reg && out_ready) begin
        out_valid_reg <= 1'b0;
      end

      case (state_reg)
        RUN: begin
          if (flush) begin
            state_reg <= DRAIN;
            busy_reg  <= 1'b1;
          end
        end
        DRAIN: begin
          if (!out_valid_reg || out_ready) begin
            state_reg <= CLEAR;
            busy_reg  <= 1'b1;
          end
        end
        CLEAR: begin
          state_reg <= RUN;
          busy_reg  <= 1'b0;
          last_reg  <= HW'(NHART - 1);
        end
        default: begin
          state_reg <= RUN;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid    = out_valid_reg;
  assign out_hart     = out_hart_reg;
  assign out_order    = out_order_reg;
  assign out_insn     = out_insn_reg;
  assign out_pc_rdata = out_pc_rdata_reg;
  assign out_pc_wdata = out_pc_wdata_reg;
  assign out_trap     = out_trap_reg;
  assign out_halt     = out_halt_reg;
  assign out_mode     = out_mode_reg;
  assign halted       = halted_vec;
  assign busy         = busy_reg;

endmodule

// File: tb/tb_rvvi_retire_arb.sv
// tb_rvvi_retire_arb: directed bench for the two-hart retirement arbiter.
// Expected records are queued when a grant is expected and compared when the
// output port transfers them.
module tb_rvvi_retire_arb;
  localparam int ILEN  = 32;
  localparam int XLEN  = 32;
  localparam int NHART = 2;
  localparam int HW    = 1;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NHART-1:0]      in_valid;
  logic [NHART-1:0]      in_ready;
  logic [NHART*ILEN-1:0] in_insn;
  logic [NHART*XLEN-1:0] in_pc_rdata;
  logic [NHART*XLEN-1:0] in_pc_wdata;
  logic [NHART-1:0]      in_trap;
  logic [NHART-1:0]      in_halt;
  logic [NHART*2-1:0]    in_mode;
  logic [NHART-1:0]      clr_halt;
  logic                  flush;
  logic                  out_valid;
  logic                  out_ready;
  logic [HW-1:0]         out_hart;
  logic [63:0]           out_order;
  logic [ILEN-1:0]       out_insn;
  logic [XLEN-1:0]       out_pc_rdata;
  logic [XLEN-1:0]       out_pc_wdata;
  logic                  out_trap;
  logic                  out_halt;
  logic [1:0]            out_mode;
  logic [NHART-1:0]      halted;
  logic                  busy;

  typedef struct packed {
    logic [HW-1:0] hart;
    logic [63:0]   order;
    logic [31:0]   insn;
    logic [31:0]   pcr;
    logic [31:0]   pcw;
    logic          trap;
    logic          halt;
    logic [1:0]    mode;
  } rec_t;

  rec_t        exp_q[$];
  int          n_pass   = 0;
  int          n_checks = 0;
  logic [15:0] seq       [NHART];
  logic        halt_flag [NHART];
  logic [63:0] model_cnt [NHART];

  rvvi_retire_arb #(.ILEN(ILEN), .XLEN(XLEN), .NHART(NHART)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_insn(in_insn), .in_pc_rdata(in_pc_rdata), .in_pc_wdata(in_pc_wdata),
    .in_trap(in_trap), .in_halt(in_halt), .in_mode(in_mode),
    .clr_halt(clr_halt), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_hart(out_hart), .out_order(out_order), .out_insn(out_insn),
    .out_pc_rdata(out_pc_rdata), .out_pc_wdata(out_pc_wdata),
    .out_trap(out_trap), .out_halt(out_halt), .out_mode(out_mode),
    .halted(halted), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] f_insn(input int h, input logic [15:0] s);
    return {4'hA, 4'(h), 8'h13, s};
  endfunction

  function automatic logic [31:0] f_pcr(input int h, input logic [15:0] s);
    return 32'h8000_0000 + (32'(h) << 20) + (32'(s) << 2);
  endfunction

  function automatic logic f_trap(input int h, input logic [15:0] s);
    return s[0] ^ h[0];
  endfunction

  task automatic drive_hart(input int h);
    in_insn[h*ILEN +: ILEN]     = f_insn(h, seq[h]);
    in_pc_rdata[h*XLEN +: XLEN] = f_pcr(h, seq[h]);
    in_pc_wdata[h*XLEN +: XLEN] = f_pcr(h, seq[h]) + 32'd4;
    in_trap[h]                  = f_trap(h, seq[h]);
    in_halt[h]                  = halt_flag[h];
    in_mode[h*2 +: 2]           = seq[h][2:1];
  endtask

  function automatic rec_t mk_rec(input int h, input logic [63:0] ord);
    rec_t r;
    r.hart  = HW'(h);
    r.order = ord;
    r.insn  = f_insn(h, seq[h]);
    r.pcr   = f_pcr(h, seq[h]);
    r.pcw   = f_pcr(h, seq[h]) + 32'd4;
    r.trap  = f_trap(h, seq[h]);
    r.halt  = halt_flag[h];
    r.mode  = seq[h][2:1];
    return r;
  endfunction

  // One clock cycle: check handshakes, queue expected grants, compare any transfer.
  task automatic cycle(input logic [NHART-1:0] exp_rdy, input logic exp_ov);
    rec_t r;
    #1;
    chk("in_ready", 64'(in_ready), 64'(exp_rdy));
    chk("out_valid", 64'(out_valid), 64'(exp_ov));
    for (int h = 0; h < NHART; h++) begin
      if (exp_rdy[h]) begin
        exp_q.push_back(mk_rec(h, model_cnt[h]));
        model_cnt[h] = model_cnt[h] + 64'd1;
      end
    end
    if (out_valid && out_ready) begin
      chk("queue_nonempty", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        r = exp_q.pop_front();
        chk("hart", 64'(out_hart), 64'(r.hart));
        chk("order", out_order, r.order);
        chk("insn", 64'(out_insn), 64'(r.insn));
        chk("pc_rdata", 64'(out_pc_rdata), 64'(r.pcr));
        chk("pc_wdata", 64'(out_pc_wdata), 64'(r.pcw));
        chk("trap_halt_mode", 64'({out_trap, out_halt, out_mode}), 64'({r.trap, r.halt, r.mode}));
        $display("txn hart=%0d order=%0h insn=%h trap=%0b halt=%0b mode=%0d",
                 out_hart, out_order, out_insn, out_trap, out_halt, out_mode);
      end
    end
    @(posedge clk);
    #1;
    for (int h = 0; h < NHART; h++) begin
      if (exp_rdy[h]) begin
        seq[h] = seq[h] + 16'd1;
        drive_hart(h);
      end
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 2'b11;
    out_ready = 1'b1;
    flush     = 1'b0;
    clr_halt  = 2'b00;
    in_insn = '0; in_pc_rdata = '0; in_pc_wdata = '0;
    in_trap = '0; in_halt = '0; in_mode = '0;
    for (int h = 0; h < NHART; h++) begin
      seq[h]       = 16'd0;
      halt_flag[h] = 1'b0;
      model_cnt[h] = 64'd0;
      drive_hart(h);
    end

    // Reset held two cycles with every hart requesting.
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd0);
    end
    chk("rst_out_order", out_order, 64'd0);
    chk("rst_out_hart", 64'(out_hart), 64'd0);
    chk("rst_out_insn", 64'(out_insn), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_halted", 64'(halted), 64'd0);
    rst_n = 1'b1;

    // Fairness: alternating grants, one per cycle, per-hart order counts.
    cycle(2'b01, 1'b0);
    cycle(2'b10, 1'b1);
    cycle(2'b01, 1'b1);
    cycle(2'b10, 1'b1);
    cycle(2'b01, 1'b1);
    cycle(2'b10, 1'b1);

    // Backpressure: fields hold, no accepts, then next grant right after release.
    out_ready = 1'b0;
    repeat (3) begin
      cycle(2'b00, 1'b1);
      chk("hold_order", out_order, exp_q[0].order);
      chk("hold_insn", 64'(out_insn), 64'(exp_q[0].insn));
    end
    out_ready = 1'b1;
    cycle(2'b01, 1'b1);

    // Halt: hart 1 retires a halting record, then is locked out until cleared.
    halt_flag[1] = 1'b1;
    drive_hart(1);
    cycle(2'b10, 1'b1);
    halt_flag[1] = 1'b0;
    drive_hart(1);
    chk("halted_set", 64'(halted), 64'(2'b10));
    cycle(2'b01, 1'b1);
    cycle(2'b01, 1'b1);
    clr_halt = 2'b10;
    cycle(2'b01, 1'b1);
    clr_halt = 2'b00;
    chk("halted_clr", 64'(halted), 64'd0);
    cycle(2'b10, 1'b1);

    // A halting grant and a clear for the same hart together: the halt sticks.
    cycle(2'b01, 1'b1);
    halt_flag[1] = 1'b1;
    drive_hart(1);
    clr_halt = 2'b10;
    cycle(2'b10, 1'b1);
    clr_halt = 2'b00;
    halt_flag[1] = 1'b0;
    drive_hart(1);
    chk("halted_set_wins", 64'(halted), 64'(2'b10));
    clr_halt = 2'b10;
    cycle(2'b01, 1'b1);
    clr_halt = 2'b00;
    chk("halted_clr2", 64'(halted), 64'd0);

    // Flush while stalled: drain, clear counters, restart with hart 0 first.
    out_ready = 1'b0;
    flush     = 1'b1;
    cycle(2'b00, 1'b1);
    flush = 1'b0;
    chk("busy_drain", 64'(busy), 64'd1);
    cycle(2'b00, 1'b1);
    chk("busy_drain_hold", 64'(busy), 64'd1);
    out_ready = 1'b1;
    cycle(2'b00, 1'b1);
    chk("busy_clear", 64'(busy), 64'd1);
    cycle(2'b00, 1'b0);
    chk("busy_run", 64'(busy), 64'd0);
    model_cnt[0] = 64'd0;
    model_cnt[1] = 64'd0;
    cycle(2'b01, 1'b0);
    cycle(2'b10, 1'b1);

    // Counter wrap on hart 0 with hart 1 idle.
    in_valid = 2'b01;
    force dut.g_hart[0].cnt_reg = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.g_hart[0].cnt_reg;
    model_cnt[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    cycle(2'b01, 1'b1);
    cycle(2'b01, 1'b1);
    in_valid = 2'b00;
    cycle(2'b00, 1'b1);
    cycle(2'b00, 1'b0);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rvvi_retire_arb.md
# rvvi_retire_arb

Round-robin arbiter that shares a single RVVI trace-record port between `NHART` per-hart retirement sources. Each hart presents one retired-instruction record at a time over a valid/ready handshake. The block grants one record per cycle, stamps it with that hart's 64-bit instruction order count, and registers it onto a shared output port with a hart id. It sits between the core retirement stages and the trace-interface driver, and it also sequences halt tracking and order-counter flush.

## Interface
Parameters:
- `ILEN`, 32, instruction length in bits
- `XLEN`, 32, PC width in bits
- `NHART`, 2, number of requesting harts (1..16); `HW = max(1, $clog2(NHART))` is a derived localparam

Ports:
- `clk` in 1: interface clock, all logic on rising edge
- `rst_n` in 1: reset, synchronous, active-low
- `in_valid` in NHART: per-hart record valid
- `in_ready` out NHART: per-hart grant/accept; a record transfers when `in_valid[h] & in_ready[h]`
- `in_insn` in NHART*ILEN: instruction bits; hart h at `[h*ILEN +: ILEN]`, and the same slicing applies to all packed buses
- `in_pc_rdata` in NHART*XLEN: PC of the instruction
- `in_pc_wdata` in NHART*XLEN: next PC
- `in_trap` in NHART: record is a trapped instruction
- `in_halt` in NHART: record is a halting instruction
- `in_mode` in NHART*2: privilege mode
- `clr_halt` in NHART: pulse that clears the sticky halted flag of hart h
- `flush` in 1: pulse that requests an order-counter flush
- `out_valid` out 1: output record valid
- `out_ready` in 1: downstream accept
- `out_hart` out HW: source hart id
- `out_order` out 64: order count stamped on the record
- `out_insn` out ILEN, `out_pc_rdata` out XLEN, `out_pc_wdata` out XLEN, `out_trap` out 1, `out_halt` out 1, `out_mode` out 2: registered copies of the granted record
- `halted` out NHART: sticky per-hart halted status
- `busy` out 1: high whenever the FSM is not in RUN

## Operation
- **Output register:**
  - Single entry.
  - `load = (state==RUN) & any_eligible & (!out_valid | out_ready)`.
  - On `load`, the granted record is captured and `out_valid` is set.
  - If `out_valid & out_ready & !load`, `out_valid` clears.
- **Eligibility:** `elig[h] = in_valid[h] & !halted[h]`.
- **Round-robin arbitration:**
  - The search starts at `(last+1) mod NHART` and wraps.
  - The first eligible hart wins; `last` updates to the winner on `load` only.
  - `in_ready` is one-hot on the winner when `load`, otherwise zero.
- **Order counters:**
  - `cnt[h]` is 64 bits, reset to 0.
  - `out_order` takes the pre-increment `cnt[h]`, then `cnt[h]` increments on grant.
  - Trap and halt records also consume an order value, so there are no gaps.
  - At 2^64−1 the counter wraps to 0.
- **Halt tracking:**
  - A granted record with `in_halt=1` sets `halted[h]` in the same edge as the load.
  - `clr_halt[h]` clears it.
  - If a grant with halt and `clr_halt` for the same hart fall in the same cycle, set wins.
- **FSM, states RUN, DRAIN, CLEAR:**
  - RUN: arbitrate normally. On `flush`, go to DRAIN; a grant in that same cycle still completes.
  - DRAIN: no grants. When `!out_valid`, or `out_valid & out_ready`, go to CLEAR.
  - CLEAR: one cycle. All `cnt` are zeroed, `last` is set to NHART−1, then go to RUN.
  - `flush` outside RUN is ignored. `halted` is unaffected by flush.
- `NHART=1`: the arbiter degenerates to a pass-through with `out_hart=0`.

## Timing
- **Reset values:**
  - `out_valid`=0, `out_hart`=0, `out_order`=0, all out data=0.
  - `halted`=0, `busy`=0, state=RUN, `last`=NHART−1 (so hart 0 has first priority), all `cnt`=0.
- **Reset mid-operation:** the pending output record is discarded and none of the record is retained.
- **Latency:** 1 cycle from input handshake to `out_valid`.
- **Throughput:** 1 record per cycle while `out_ready`=1.
- `in_ready` is combinational from `in_valid`, `halted`, `out_valid`, `out_ready` and state. There is no combinational path from `in_valid[h]` to `in_ready[h]` other than through arbitration.
- While `out_valid & !out_ready`, all out fields hold stable and `in_ready`=0.
- `busy` is registered from the state: high in DRAIN and CLEAR.

## Test plan
- **Reset:** drive `rst_n`=0 for 2 cycles with all `in_valid`=1 -> `out_valid`=0 and `in_ready`=0 throughout; first grant after release goes to hart 0 with `out_order`=0.
- **Fairness:** NHART=2, both harts continuously valid, `out_ready`=1 -> `out_hart` alternates 0,1,0,1; each hart's `out_order` runs 0,1,2,… with no gaps; one record per cycle.
- **Backpressure:** hold `out_ready`=0 for 3 cycles with a record loaded -> out fields stable, `in_ready`=0; on release, the next grant appears the following cycle.
- **Halt:** hart 1 record with `in_halt`=1 -> `halted[1]`=1; later hart 1 requests are never granted while hart 0 keeps flowing; `clr_halt[1]` pulse -> hart 1 is granted again, continuing its order count.
- **Flush:** after hart 0 reaches order 5, pulse `flush` with `out_ready`=0 -> `busy`=1, no grants while stalled; release `out_ready` -> CLEAR, next hart 0 record has `out_order`=0 and hart 0 is granted first.
- **Wrap:** force `cnt[0]` to 2^64−1 -> that record reports 0xFFFF_FFFF_FFFF_FFFF and the next reports 0.
